// File: rtl/tub_scan_controller.sv
// tub_scan_controller
//
// Time-multiplexes a DIGITS-wide seven-segment display through one shared
// single-digit hex decoder. A display word (one nibble per digit, digit 0
// rightmost) and a per-digit enable mask are scanned one digit at a time,
// each digit held for SCAN_DIV clock cycles.
//
// New words arrive over a valid/ready handshake. They are applied only at
// a frame boundary, which is the last cycle of the last digit. A frame is
// therefore never shown half old and half new.
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN - when defined, digit i>0 is also blanked if
//                           nibbles i..DIGITS-1 of the shown word are all
//                           zero. This test is ANDed with the enable mask.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   load_valid  a new word and mask are offered
//   load_ready  a word can be accepted (no word is waiting for a boundary)
//   load_data   display word; nibble i drives digit i
//   load_mask   per-digit enable; 1 = digit lit
//   tub_data    nibble for the hex decoder
//   tub_sel     one-hot active-high digit select; all zero = blank
//   frame_done  one-cycle pulse on the last cycle of each frame
module tub_scan_controller #(
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 100000,
   localparam int DATA_W  = 4 * DIGITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic [DIGITS-1:0] load_mask,
   output logic [3:0]        tub_data,
   output logic [DIGITS-1:0] tub_sel,
   output logic              frame_done
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [CNT_W-1:0]  div_cnt_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [DATA_W-1:0] shown_data_reg;
   logic [DIGITS-1:0] shown_mask_reg;
   logic [DATA_W-1:0] pend_data_reg;
   logic [DIGITS-1:0] pend_mask_reg;
   logic              pending_reg;

   logic              div_last;
   logic              boundary;
   logic              accept;

   assign div_last = (div_cnt_reg == DIV_LAST);
   assign boundary = div_last && (idx_reg == IDX_LAST);
   // load_ready is ~pending, so an accept can never collide with a
   // pending word being applied on the same boundary.
   assign accept   = load_valid && !pending_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_reg    <= '0;
         idx_reg        <= '0;
         shown_data_reg <= '0;
         shown_mask_reg <= '1;
         pend_data_reg  <= '0;
         pend_mask_reg  <= '0;
         pending_reg    <= 1'b0;
      end else begin
         div_cnt_reg <= div_last ? '0 : div_cnt_reg + CNT_W'(1);

         if (div_last) begin
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
         end

         if (boundary) begin
            if (pending_reg) begin
               shown_data_reg <= pend_data_reg;
               shown_mask_reg <= pend_mask_reg;
               pending_reg    <= 1'b0;
            end else if (accept) begin
               // Accepted on the boundary itself: go straight to the
               // display, since the next cycle starts a fresh frame.
               shown_data_reg <= load_data;
               shown_mask_reg <= load_mask;
            end
         end else if (accept) begin
            pend_data_reg <= load_data;
            pend_mask_reg <= load_mask;
            pending_reg   <= 1'b1;
         end
      end
   end

   // Per-digit decode: select match, nibble steering and blanking.
   logic [DIGITS-1:0] digit_hit;
   logic [DIGITS-1:0] digit_keep;
   logic [3:0]        digit_nib [DIGITS];

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign digit_hit[gi] = (idx_reg == IDX_W'(gi));
         assign digit_nib[gi] = digit_hit[gi] ? shown_data_reg[4*gi +: 4] : 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
         if (gi == 0) begin : g_lsd
            // The rightmost digit always shows, so a zero word reads "0".
            assign digit_keep[gi] = 1'b1;
         end else begin : g_upper
            assign digit_keep[gi] = |shown_data_reg[DATA_W-1:4*gi];
         end
`else
         assign digit_keep[gi] = 1'b1;
`endif
      end
   endgenerate

   always_comb begin
      tub_data = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         tub_data = tub_data | digit_nib[i];
      end
   end

   assign tub_sel    = digit_hit & shown_mask_reg & digit_keep;
   assign frame_done = boundary;
   assign load_ready = ~pending_reg;

endmodule

// File: tb/tb_tub_scan_controller.sv
// Testbench for tub_scan_controller with DIGITS=8 and SCAN_DIV=4, giving a
// 32-cycle frame. Directed scenarios run first, then randomized traffic.
// Every cycle, all outputs are checked against a reference model. The
// model tracks time since reset and applies the handshake and frame rules
// directly to whole words.
module tb_tub_scan_controller;

   localparam int D  = 8;
   localparam int SD = 4;
   localparam int FRAME = D * SD;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic [31:0]   load_data = '0;
   logic [7:0]    load_mask = '0;
   logic [3:0]    tub_data;
   logic [7:0]    tub_sel;
   logic          frame_done;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int            t;        // cycles since reset release
   logic [31:0]   m_shown;
   logic [7:0]    m_smask;
   logic [31:0]   m_pend;
   logic [7:0]    m_pmask;
   bit            m_pending;

   tub_scan_controller #(.DIGITS(D), .SCAN_DIV(SD)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_mask  (load_mask),
      .tub_data   (tub_data),
      .tub_sel    (tub_sel),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   function automatic bit lead_blank(input int d, input logic [31:0] w);
`ifdef LEADING_ZERO_BLANK_EN
      return (d > 0) && ((w >> (4 * d)) == 32'd0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_outputs();
      int d;
      logic [7:0] exp_sel;
      d = (t / SD) % D;
      exp_sel = (m_smask[d] && !lead_blank(d, m_shown)) ? 8'(1 << d) : 8'h00;
      chk("tub_data",   32'(tub_data),   (m_shown >> (4 * d)) & 32'hF);
      chk("tub_sel",    32'(tub_sel),    32'(exp_sel));
      chk("frame_done", 32'(frame_done), 32'((t % FRAME) == FRAME - 1));
      chk("load_ready", 32'(load_ready), 32'(!m_pending));
   endtask

   // One clock cycle: drive the inputs, check the outputs from current
   // state, then advance the model across the clock edge.
   task automatic cycle(input bit v, input logic [31:0] data, input logic [7:0] mask);
      bit bnd;
      load_valid = v;
      load_data  = data;
      load_mask  = mask;
      check_outputs();
      $display("t=%0d valid=%0b data=%08h mask=%02h sel=%02h nib=%0h ready=%0b fd=%0b",
               t, v, data, mask, tub_sel, tub_data, load_ready, frame_done);
      bnd = (t % FRAME) == FRAME - 1;
      if (bnd) begin
         if (m_pending) begin
            m_shown = m_pend; m_smask = m_pmask; m_pending = 0;
         end else if (v) begin
            m_shown = data; m_smask = mask;
         end
      end else if (v && !m_pending) begin
         m_pend = data; m_pmask = mask; m_pending = 1;
      end
      t++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 8'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      load_valid = 1'b0;
      @(posedge clk);
      #1;
      t = 0; m_shown = '0; m_smask = '1; m_pend = '0; m_pmask = '0; m_pending = 0;
      chk("rst_sel",   32'(tub_sel),    32'h01);
      chk("rst_data",  32'(tub_data),   32'h0);
      chk("rst_ready", 32'(load_ready), 32'h1);
      chk("rst_fd",    32'(frame_done), 32'h0);
      $display("reset sel=%02h nib=%0h ready=%0b", tub_sel, tub_data, load_ready);
      rst = 1'b0;
   endtask

   initial begin
      bit accepted;
      t = 0; m_shown = '0; m_smask = '1; m_pend = '0; m_pmask = '0; m_pending = 0;
      @(posedge clk);
      #1;

      // 1: idle frame after reset
      do_reset();
      idle(FRAME);

      // 2: load mid-frame, applied at next boundary
      do_reset();
      idle(5);
      cycle(1'b1, 32'h1234ABCD, 8'hFF);
      idle(2 * FRAME - 6);

      // 3: load on the boundary cycle itself
      do_reset();
      idle(FRAME - 1);
      cycle(1'b1, 32'hCAFEF00D, 8'hFF);
      idle(FRAME);

      // 4: second word held while the first is pending
      do_reset();
      idle(5);
      cycle(1'b1, 32'h22222222, 8'hFF);
      accepted = 0;
      for (int i = 6; i < 3 * FRAME; i++) begin
         if (!accepted) begin
            accepted = !m_pending && ((t % FRAME) != FRAME - 1 || !m_pending);
            cycle(1'b1, 32'h11111111, 8'hFF);
         end else begin
            cycle(1'b0, 32'h0, 8'h0);
         end
      end

      // 5: partial mask
      do_reset();
      cycle(1'b1, 32'h87654321, 8'h0F);
      idle(2 * FRAME);

      // 6: leading-zero words (blanking depends on build)
      do_reset();
      cycle(1'b1, 32'h000000A5, 8'hFF);
      idle(2 * FRAME);
      cycle(1'b1, 32'h00000000, 8'hFF);
      idle(2 * FRAME);

      // 7: reset while a word is pending
      do_reset();
      idle(5);
      cycle(1'b1, 32'hDEADBEEF, 8'hFF);
      idle(14);
      do_reset();
      idle(2 * FRAME);

      // Randomized traffic with occasional resets
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(0, 3) == 0, $urandom, 8'($urandom));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
